// File: rtl/rv32i_wb_arbiter_if.sv
// rv32i_wb_arbiter_if
//   Bundles the writeback arbiter's source and regfile-side signals.
//   master : the execute/memory stages plus regfile observer (drives alu_*/mem_* requests)
//   slave  : the arbiter itself (drives alu_stall, mem_ready, wr/rd_addr/rd, pend)
//   Signals:
//     alu_valid/alu_rd_addr/alu_rd   ALU/CSR result, high priority, no backpressure
//     alu_stall                      ALU must hold its result this cycle
//     mem_valid/mem_rd_addr/mem_rd   load result, ready/valid handshake
//     mem_ready                      load FIFO can accept
//     wr/rd_addr/rd                  registered regfile write port
//     pend                           live queued load targets (bit 0 always 0)
interface rv32i_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd;
    logic        wr;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic [31:0] pend;

    modport master (
        output alu_valid, alu_rd_addr, alu_rd,
        output mem_valid, mem_rd_addr, mem_rd,
        input  alu_stall, mem_ready, wr, rd_addr, rd, pend
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_rd,
        input  mem_valid, mem_rd_addr, mem_rd,
        output alu_stall, mem_ready, wr, rd_addr, rd, pend
    );
endinterface

// File: rtl/rv32i_wb_arbiter.sv
// rv32i_wb_arbiter
//   Shares the single regfile write port between ALU/CSR results (high
//   priority, no backpressure) and load results (low priority, buffered in a
//   DEPTH-entry FIFO). A starvation FSM forces a FIFO drain after the head has
//   lost STARVE_MAX consecutive cycles to the ALU. Queued loads overwritten by
//   a younger ALU write are marked dead and drain without writing.
//   Ports:
//     clk  : clock, all state on posedge
//     rst  : asynchronous active-high reset
//     bus  : rv32i_wb_arbiter_if.slave (ALU/load inputs, stall/ready,
//            registered wr/rd_addr/rd, pend scoreboard)
module rv32i_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    rv32i_wb_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_e;

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [4:0]       fifo_addr_d [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_data_d [DEPTH];
    logic [DEPTH-1:0] fifo_dead_q, fifo_dead_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    state_e           state_q, state_d;
    logic             alu_stall_q, alu_stall_d;
    logic             wr_q, wr_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_q, rd_d;

    logic             mem_ready;
    logic             alu_acc;
    logic             mem_acc;
    logic             fifo_ne;
    logic             head_dead;
    logic             alu_kill;
    logic             load_killed;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] slot_live;
    logic [31:0]      pend;

    // Handshake and arbitration qualifiers; mem_ready depends on count only.
    always_comb begin
        mem_ready   = (count_q < (PTR_W+1)'(DEPTH));
        alu_acc     = bus.alu_valid && !alu_stall_q;
        mem_acc     = bus.mem_valid && mem_ready;
        fifo_ne     = (count_q != '0);
        head_dead   = fifo_dead_q[head_q];
        alu_kill    = alu_acc && (bus.alu_rd_addr != 5'd0);
        load_killed = alu_kill && (bus.mem_rd_addr == bus.alu_rd_addr);
    end

    // A slot is occupied when its distance from head is below count.
    always_comb begin
        slot_live = '0;
        pend      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_live[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
            if (slot_live[i] && !fifo_dead_q[i]) begin
                pend[fifo_addr_q[i]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    // Datapath: arbitration, FIFO push/pop, WAW kill, registered write port.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_dead_d = fifo_dead_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        wr_d        = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_d        = rd_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (alu_acc) begin
            if (bus.alu_rd_addr != 5'd0) begin
                wr_d      = 1'b1;
                rd_addr_d = bus.alu_rd_addr;
                rd_d      = bus.alu_rd;
            end
            // A dead head drains alongside an ALU win.
            pop  = fifo_ne && head_dead;
            push = mem_acc && (bus.mem_rd_addr != 5'd0) && !load_killed;
        end else if (fifo_ne) begin
            pop = 1'b1;
            if (!head_dead) begin
                wr_d      = 1'b1;
                rd_addr_d = fifo_addr_q[head_q];
                rd_d      = fifo_data_q[head_q];
            end
            push = mem_acc && (bus.mem_rd_addr != 5'd0);
        end else if (mem_acc && (bus.mem_rd_addr != 5'd0)) begin
            wr_d      = 1'b1;
            rd_addr_d = bus.mem_rd_addr;
            rd_d      = bus.mem_rd;
        end

        // Kill is applied before the push so a freshly pushed slot starts live;
        // stale dead bits on empty slots are harmless for the same reason.
        if (alu_kill) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (fifo_addr_q[i] == bus.alu_rd_addr) begin
                    fifo_dead_d[i] = 1'b1;
                end
            end
        end

        if (push) begin
            fifo_addr_d[tail_q] = bus.mem_rd_addr;
            fifo_data_d[tail_q] = bus.mem_rd;
            fifo_dead_d[tail_q] = 1'b0;
            tail_d              = tail_q + PTR_W'(1);
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Starvation FSM. In ST_FORCE alu_stall_q blocks the ALU, so the normal
    // arbitration above pops the head without a dedicated path.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (alu_acc && fifo_ne) begin
                    if (starve_cnt_q == CNT_W'(STARVE_MAX - 1)) begin
                        state_d      = ST_FORCE;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ST_FORCE: begin
                state_d      = ST_NORMAL;
                starve_cnt_d = '0;
            end
            default: begin
                state_d      = ST_NORMAL;
                starve_cnt_d = '0;
            end
        endcase
        alu_stall_d = (state_d == ST_FORCE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_dead_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            state_q      <= ST_NORMAL;
            alu_stall_q  <= 1'b0;
            wr_q         <= 1'b0;
            rd_addr_q    <= '0;
            rd_q         <= '0;
        end else begin
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            fifo_dead_q  <= fifo_dead_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            state_q      <= state_d;
            alu_stall_q  <= alu_stall_d;
            wr_q         <= wr_d;
            rd_addr_q    <= rd_addr_d;
            rd_q         <= rd_d;
        end
    end

    assign bus.alu_stall = alu_stall_q;
    assign bus.mem_ready = mem_ready;
    assign bus.wr        = wr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd        = rd_q;
    assign bus.pend      = pend;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb_rv32i_wb_arbiter
//   Directed bench for rv32i_wb_arbiter. Expected regfile writes are queued
//   as stimulus is driven and popped each cycle wr is high; status outputs
//   (alu_stall, mem_ready, pend) are checked at hand-derived cycles.
module tb_rv32i_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    wr_t  exp_q[$];

    rv32i_wb_arbiter_if bus ();

    rv32i_wb_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd_addr = '0;
        bus.alu_rd      = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_rd      = '0;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid   = 1'b1;
        bus.alu_rd_addr = a;
        bus.alu_rd      = d;
    endtask

    task automatic ld(input logic [4:0] a, input logic [31:0] d);
        bus.mem_valid   = 1'b1;
        bus.mem_rd_addr = a;
        bus.mem_rd      = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance one cycle; any write seen must match the scoreboard head.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.wr) begin
            check("sb_expected_wr", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, bus.rd_addr}, {27'd0, e.addr});
                check("wr_data", bus.rd, e.data);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_wr",        {31'd0, bus.wr},        32'd0);
        check("rst_rd_addr",   {27'd0, bus.rd_addr},   32'd0);
        check("rst_rd",        bus.rd,                 32'd0);
        check("rst_alu_stall", {31'd0, bus.alu_stall}, 32'd0);
        check("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        check("rst_pend",      bus.pend,               32'd0);
        rst = 1'b0;

        // ALU write, one-cycle latency, single-cycle wr, held address/data
        idle(); alu(5'd5, 32'h1234); expect_wr(5'd5, 32'h1234);
        tick();
        check("s1_wr", {31'd0, bus.wr}, 32'd1);
        idle();
        tick();
        check("s1_wr_low",    {31'd0, bus.wr},      32'd0);
        check("s1_hold_addr", {27'd0, bus.rd_addr}, 32'd5);
        check("s1_hold_data", bus.rd,               32'h1234);

        // Load bypass with empty FIFO
        idle(); ld(5'd7, 32'hAA);
        check("s2_ready", {31'd0, bus.mem_ready}, 32'd1);
        expect_wr(5'd7, 32'hAA);
        tick();
        check("s2_wr",   {31'd0, bus.wr}, 32'd1);
        check("s2_pend", bus.pend,        32'd0);
        idle();
        tick();
        check("s2_wr_low", {31'd0, bus.wr}, 32'd0);

        // Starvation: load x3 queued behind an ALU stream
        idle(); alu(5'd1, 32'd100); ld(5'd3, 32'h33); expect_wr(5'd1, 32'd100);
        tick();
        check("s3_pend_q",  bus.pend,               32'h8);
        check("s3_stall_0", {31'd0, bus.alu_stall}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            idle(); alu(5'd1, 32'd100 + 32'(k)); expect_wr(5'd1, 32'd100 + 32'(k));
            tick();
            check("s3_stall", {31'd0, bus.alu_stall}, (k == 4) ? 32'd1 : 32'd0);
            check("s3_pend",  bus.pend,               32'h8);
        end
        idle(); alu(5'd1, 32'd200); expect_wr(5'd3, 32'h33);
        tick();
        check("s3_stall_off", {31'd0, bus.alu_stall}, 32'd0);
        check("s3_pend_clr",  bus.pend,               32'd0);
        idle(); alu(5'd1, 32'd200); expect_wr(5'd1, 32'd200);
        tick();
        idle();
        tick();
        check("s3_idle_wr", {31'd0, bus.wr}, 32'd0);

        // WAW kill: queued x9 load superseded by ALU x9
        idle(); alu(5'd2, 32'h22); ld(5'd9, 32'd1); expect_wr(5'd2, 32'h22);
        tick();
        check("s4_pend_q", bus.pend, 32'h200);
        idle(); alu(5'd9, 32'd2); expect_wr(5'd9, 32'd2);
        tick();
        check("s4_pend_dead", bus.pend,               32'd0);
        check("s4_ready",     {31'd0, bus.mem_ready}, 32'd1);
        idle(); alu(5'd4, 32'h44); expect_wr(5'd4, 32'h44);
        tick();
        idle();
        tick();
        check("s4_no_dead_wr", {31'd0, bus.wr}, 32'd0);

        // Fill FIFO, backpressure, pop then accept
        idle(); alu(5'd1, 32'd300); ld(5'd10, 32'hA0); expect_wr(5'd1, 32'd300);
        tick();
        check("s5_ready_1", {31'd0, bus.mem_ready}, 32'd1);
        check("s5_pend_1",  bus.pend,               32'h400);
        idle(); alu(5'd1, 32'd301); ld(5'd11, 32'hB0); expect_wr(5'd1, 32'd301);
        tick();
        check("s5_full",   {31'd0, bus.mem_ready}, 32'd0);
        check("s5_pend_2", bus.pend,               32'hC00);
        idle(); alu(5'd1, 32'd302); ld(5'd12, 32'hC0); expect_wr(5'd1, 32'd302);
        tick();
        check("s5_still_full", {31'd0, bus.mem_ready}, 32'd0);
        check("s5_no_push",    bus.pend,               32'hC00);
        idle(); ld(5'd12, 32'hC0); expect_wr(5'd10, 32'hA0);
        tick();
        check("s5_ready_back", {31'd0, bus.mem_ready}, 32'd1);
        check("s5_pend_3",     bus.pend,               32'h800);
        idle(); ld(5'd12, 32'hC0); expect_wr(5'd11, 32'hB0);
        tick();
        check("s5_pend_4", bus.pend, 32'h1000);
        idle(); expect_wr(5'd12, 32'hC0);
        tick();
        check("s5_pend_empty", bus.pend, 32'd0);
        idle();
        tick();
        check("s5_idle_wr", {31'd0, bus.wr}, 32'd0);

        // x0 writes from both sources
        idle(); alu(5'd0, 32'hDEAD); ld(5'd0, 32'hBEEF);
        tick();
        check("s6_x0_both", {31'd0, bus.wr}, 32'd0);
        check("s6_pend",    bus.pend,        32'd0);
        idle(); ld(5'd0, 32'd1);
        check("s6_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        check("s6_x0_ld",     {31'd0, bus.wr}, 32'd0);
        check("s6_pend_ld",   bus.pend,        32'd0);
        idle(); alu(5'd0, 32'd2);
        tick();
        check("s6_x0_alu", {31'd0, bus.wr}, 32'd0);
        idle();
        tick();
        check("s6_x0_drain", {31'd0, bus.wr}, 32'd0);

        // Reset with FIFO full
        idle(); alu(5'd1, 32'd400); ld(5'd13, 32'hD0); expect_wr(5'd1, 32'd400);
        tick();
        idle(); alu(5'd1, 32'd401); ld(5'd14, 32'hE0); expect_wr(5'd1, 32'd401);
        tick();
        check("s7_full", {31'd0, bus.mem_ready}, 32'd0);
        check("s7_pend", bus.pend,               32'h6000);
        idle(); alu(5'd6, 32'h66);
        rst = 1'b1;
        #1;
        check("s7_rst_wr",    {31'd0, bus.wr},        32'd0);
        check("s7_rst_pend",  bus.pend,               32'd0);
        check("s7_rst_ready", {31'd0, bus.mem_ready}, 32'd1);
        check("s7_rst_stall", {31'd0, bus.alu_stall}, 32'd0);
        tick();
        check("s7_rst_hold_wr", {31'd0, bus.wr}, 32'd0);
        rst = 1'b0;
        idle();
        tick();
        tick();
        check("s7_post_wr",   {31'd0, bus.wr}, 32'd0);
        check("s7_post_pend", bus.pend,        32'd0);

        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
